// File: rtl/id_ex_issue_pkg.sv
// id_ex_issue_pkg: ALU operation encodings, MIPS opcode/funct values and the
// decoded-control bundle shared by the decode/issue stage and the ALU.
package id_ex_issue_pkg;

  // ALU operation select driven on aluop (the ALU decodes the same values).
  typedef enum logic [2:0] {
    ALUOP_ADD = 3'd0,
    ALUOP_SUB = 3'd1,
    ALUOP_AND = 3'd2,
    ALUOP_OR  = 3'd3,
    ALUOP_XOR = 3'd4,
    ALUOP_NOR = 3'd5,
    ALUOP_SLT = 3'd6,
    ALUOP_LUI = 3'd7
  } aluop_e;

  // Primary opcodes, instr[31:26].
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes, instr[5:0].
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // Source of ALU operand b.
  typedef enum logic [1:0] {
    BSEL_RT   = 2'd0,
    BSEL_SEXT = 2'd1,
    BSEL_ZEXT = 2'd2
  } bsel_e;

  // Which instruction field names the destination register.
  typedef enum logic [1:0] {
    WSEL_NONE = 2'd0,
    WSEL_RD   = 2'd1,
    WSEL_RT   = 2'd2
  } wsel_e;

  // Everything the decoder derives from op/fn alone.
  typedef struct packed {
    aluop_e aluop;
    bsel_e  b_sel;
    wsel_e  wr_sel;
    logic   reg_we;
    logic   mem_rd;
    logic   mem_wr;
    logic   branch;
    logic   illegal;
  } dec_ctrl_t;

endpackage

// File: rtl/id_ex_issue_alu_ctrl_dec.sv
// id_ex_issue_alu_ctrl_dec: purely combinational op/fn decoder producing the
// ALU operation, immediate-extension select and EX/MEM control bits.
module id_ex_issue_alu_ctrl_dec
  import id_ex_issue_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] fn,
  output dec_ctrl_t  ctrl
);

  // Map opcode/funct onto control; anything unrecognised becomes illegal.
  always_comb begin
    // NOTE: every field gets a value before the case so no path leaves a latch.
    ctrl         = '0;
    ctrl.aluop   = ALUOP_ADD;
    ctrl.b_sel   = BSEL_RT;
    ctrl.wr_sel  = WSEL_NONE;
    case (op)
      OP_RTYPE: begin
        ctrl.wr_sel = WSEL_RD;
        ctrl.reg_we = 1'b1;
        case (fn)
          FN_ADD, FN_ADDU: ctrl.aluop = ALUOP_ADD;
          FN_SUB, FN_SUBU: ctrl.aluop = ALUOP_SUB;
          FN_AND:          ctrl.aluop = ALUOP_AND;
          FN_OR:           ctrl.aluop = ALUOP_OR;
          FN_XOR:          ctrl.aluop = ALUOP_XOR;
          FN_NOR:          ctrl.aluop = ALUOP_NOR;
          FN_SLT:          ctrl.aluop = ALUOP_SLT;
          default: begin
            ctrl.wr_sel  = WSEL_NONE;
            ctrl.reg_we  = 1'b0;
            ctrl.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.wr_sel = WSEL_RT;
        ctrl.reg_we = 1'b1;
        case (op)
          OP_SLTI: begin ctrl.aluop = ALUOP_SLT; ctrl.b_sel = BSEL_SEXT; end
          OP_ANDI: begin ctrl.aluop = ALUOP_AND; ctrl.b_sel = BSEL_ZEXT; end
          OP_ORI:  begin ctrl.aluop = ALUOP_OR;  ctrl.b_sel = BSEL_ZEXT; end
          OP_XORI: begin ctrl.aluop = ALUOP_XOR; ctrl.b_sel = BSEL_ZEXT; end
          OP_LUI:  begin ctrl.aluop = ALUOP_LUI; ctrl.b_sel = BSEL_ZEXT; end
          default: begin ctrl.aluop = ALUOP_ADD; ctrl.b_sel = BSEL_SEXT; end
        endcase
      end
      OP_LW: begin
        ctrl.b_sel  = BSEL_SEXT;
        ctrl.wr_sel = WSEL_RT;
        ctrl.reg_we = 1'b1;
        ctrl.mem_rd = 1'b1;
      end
      OP_SW: begin
        ctrl.b_sel  = BSEL_SEXT;
        ctrl.mem_wr = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.aluop  = ALUOP_SUB;
        ctrl.branch = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_issue.sv
// id_ex_issue: MIPS decode/issue stage feeding the ALU through a one-entry
// ID/EX slot with valid/ready flow control. Defining ID_EX_FWD_EN adds MEM/WB
// operand-forwarding ports applied to rs_val/rt_val at accept time.
module id_ex_issue
  import id_ex_issue_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  input  logic [DW-1:0] rs_val,
  input  logic [DW-1:0] rt_val,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
  output logic [2:0]    aluop,
  output logic [DW-1:0] store_data,
  output logic [RW-1:0] wr_reg,
  output logic          reg_we,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic          branch,
  output logic          illegal
`ifdef ID_EX_FWD_EN
  ,
  input  logic          fwd_mem_we,
  input  logic [RW-1:0] fwd_mem_reg,
  input  logic [DW-1:0] fwd_mem_data,
  input  logic          fwd_wb_we,
  input  logic [RW-1:0] fwd_wb_reg,
  input  logic [DW-1:0] fwd_wb_data
`endif
);

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] store_data;
    logic [2:0]    aluop;
    logic [RW-1:0] wr_reg;
    logic          reg_we;
    logic          mem_rd;
    logic          mem_wr;
    logic          branch;
    logic          illegal;
  } slot_t;

  dec_ctrl_t     ctrl;
  logic [DW-1:0] rs_op;
  logic [DW-1:0] rt_op;
  slot_t         issue;
  slot_t         slot_d, slot_q;
  logic          valid_d, valid_q;
  logic          accept;
  logic          unused_shamt;

  // Shift amount is not consumed by any supported instruction.
  assign unused_shamt = ^instr[10:6];

  id_ex_issue_alu_ctrl_dec u_dec (
    .op   (instr[31:26]),
    .fn   (instr[5:0]),
    .ctrl (ctrl)
  );

`ifdef ID_EX_FWD_EN
  logic [RW-1:0] rs_idx;
  logic [RW-1:0] rt_idx;
  assign rs_idx = RW'(instr[25:21]);
  assign rt_idx = RW'(instr[20:16]);

  // Override register-file operands with in-flight results; MEM is newer than
  // WB so it is applied last, and $0 is hard-wired so it is never forwarded.
  always_comb begin
    rs_op = rs_val;
    rt_op = rt_val;
    if (rs_idx != '0 && fwd_wb_we  && fwd_wb_reg  == rs_idx) rs_op = fwd_wb_data;
    if (rs_idx != '0 && fwd_mem_we && fwd_mem_reg == rs_idx) rs_op = fwd_mem_data;
    if (rt_idx != '0 && fwd_wb_we  && fwd_wb_reg  == rt_idx) rt_op = fwd_wb_data;
    if (rt_idx != '0 && fwd_mem_we && fwd_mem_reg == rt_idx) rt_op = fwd_mem_data;
  end
`else
  logic unused_rs_idx;
  assign unused_rs_idx = ^instr[25:21];
  assign rs_op = rs_val;
  assign rt_op = rt_val;
`endif

  // Assemble the slot contents that an accepted instruction would load.
  always_comb begin
    issue            = '0;
    issue.a          = rs_op;
    issue.store_data = rt_op;
    issue.aluop      = ctrl.aluop;
    case (ctrl.b_sel)
      BSEL_SEXT: issue.b = {{(DW-16){instr[15]}}, instr[15:0]};
      BSEL_ZEXT: issue.b = {{(DW-16){1'b0}}, instr[15:0]};
      default:   issue.b = rt_op;
    endcase
    case (ctrl.wr_sel)
      WSEL_RD: issue.wr_reg = RW'(instr[15:11]);
      WSEL_RT: issue.wr_reg = RW'(instr[20:16]);
      default: issue.wr_reg = '0;
    endcase
    // Writing $0 is a no-op, so the enable is dropped with it.
    issue.reg_we  = ctrl.reg_we & (issue.wr_reg != '0);
    issue.mem_rd  = ctrl.mem_rd;
    issue.mem_wr  = ctrl.mem_wr;
    issue.branch  = ctrl.branch;
    issue.illegal = ctrl.illegal;
  end

  assign in_ready = ~valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  // Slot update: flush beats accept; drain clears valid but leaves data alone.
  always_comb begin
    valid_d = valid_q;
    slot_d  = slot_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      slot_d  = issue;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Slot register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      // NOTE: the data fields are reset as well because every output must read 0 in reset.
      valid_q <= 1'b0;
      slot_q  <= '0;
    end else begin
      // NOTE: non-blocking so all flops sample the pre-edge values together.
      valid_q <= valid_d;
      slot_q  <= slot_d;
    end
  end

  assign out_valid  = valid_q;
  assign a          = slot_q.a;
  assign b          = slot_q.b;
  assign aluop      = slot_q.aluop;
  assign store_data = slot_q.store_data;
  assign wr_reg     = slot_q.wr_reg;
  assign reg_we     = slot_q.reg_we;
  assign mem_rd     = slot_q.mem_rd;
  assign mem_wr     = slot_q.mem_wr;
  assign branch     = slot_q.branch;
  assign illegal    = slot_q.illegal;

endmodule
